// File: rtl/alu_mc_if.sv
// alu_mc_if: sequencer-to-ALU bus carrying operands, handshake, results and flags
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zout;
    logic             cout;
    logic             ovf;
    logic             z_write;
    logic             c_write;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, result_hi, zout, cout, ovf, z_write, c_write
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, result_hi, zout, cout, ovf, z_write, c_write
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: registered WIDTH-bit ALU with flags and an iterative shift-add multiplier
module alu_mc #(
    parameter int WIDTH = 8
) (
    input logic   clk,
    input logic   reset_n,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_PASB = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SBC  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_ROL  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     count_q, count_d;
    logic               done_q, done_d;
    logic               zout_q, zout_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zw_q, zw_d;
    logic               cw_q, cw_d;

    logic [SHW-1:0]     amt;
    logic [WIDTH-1:0]   b_eff;
    logic               add_cin;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] rol_wide;
    logic [WIDTH-1:0]   sra_res;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_z, alu_c, alu_v, alu_zw, alu_cw;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    // Single-cycle datapath: SUB/SBC invert b (op[1]); ADC/SBC take cin (op[0]), SUB forces carry-in 1
    always_comb begin
        amt      = bus.b[SHW-1:0];
        b_eff    = bus.op[1] ? ~bus.b : bus.b;
        add_cin  = bus.op[0] ? bus.cin : bus.op[1];
        sum      = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_cin};
        rol_wide = {bus.a, bus.a} << amt;
        sra_res  = $signed(bus.a) >>> amt;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_zw   = 1'b1;
        alu_cw   = 1'b0;
        case (bus.op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_PASB: alu_res = bus.b;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
                alu_cw  = 1'b1;
            end
            OP_SLL:  alu_res = bus.a << amt;
            OP_SRL:  alu_res = bus.a >> amt;
            OP_SRA:  alu_res = sra_res;
            OP_ROL:  alu_res = rol_wide[2*WIDTH-1:WIDTH];
            default: alu_zw  = 1'b0;
        endcase
        alu_z = alu_zw && (alu_res == '0);
    end

    // One multiplier step: conditionally add multiplicand into the upper half, then shift {carry, acc} right
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Next-state and result/flag capture; outputs hold unless a done is being produced
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        done_d   = 1'b0;
        zout_d   = zout_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zw_d     = zw_q;
        cw_d     = cw_q;
        if (state_q == S_IDLE) begin
            if (bus.start && bus.op == OP_MUL) begin
                state_d  = S_MUL;
                mcand_d  = bus.a;
                mplier_d = bus.b;
                acc_d    = '0;
                count_d  = '0;
            end else if (bus.start) begin
                done_d   = 1'b1;
                result_d = alu_res;
                hi_d     = '0;
                zout_d   = alu_z;
                cout_d   = alu_c;
                ovf_d    = alu_v;
                zw_d     = alu_zw;
                cw_d     = alu_cw;
            end
        end else begin
            acc_d    = mul_next;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (count_q == SHW'(WIDTH - 1)) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = mul_next[WIDTH-1:0];
                hi_d     = mul_next[2*WIDTH-1:WIDTH];
                zout_d   = (mul_next == '0);
                cout_d   = (mul_next[2*WIDTH-1:WIDTH] != '0);
                ovf_d    = 1'b0;
                zw_d     = 1'b1;
                cw_d     = 1'b1;
            end
        end
    end

    // State, multiplier and output registers; reset abandons any multiply in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            zout_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zw_q     <= 1'b0;
            cw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            done_q   <= done_d;
            zout_q   <= zout_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zw_q     <= zw_d;
            cw_q     <= cw_d;
        end
    end

    assign bus.busy      = (state_q == S_MUL);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_hi = hi_q;
    assign bus.zout      = zout_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.z_write   = zw_q;
    assign bus.c_write   = cw_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table and multi-cycle sequences against alu_mc, scoreboarded on done
module tb_alu_mc;
    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       z;
        logic       c;
        logic       v;
        logic       zw;
        logic       cw;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        exp_t       e;
    } vec_t;

    logic   clk;
    logic   reset_n;
    vec_t   vt[$];
    exp_t   q[$];
    exp_t   got_r;
    exp_t   exp_r;
    int     checks;
    int     passed;
    int     done_count;
    int     base;

    alu_mc_if #(.WIDTH(8)) bus();

    alu_mc #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s got=%h expected=%h", name, got, want);
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [7:0] r, input logic z, input logic c, input logic v,
                           input logic zw, input logic cw);
        vec_t t;
        t.op  = op;
        t.a   = a;
        t.b   = b;
        t.cin = cin;
        t.e   = {r, 8'h00, z, c, v, zw, cw};
        vt.push_back(t);
    endtask

    // Scoreboard: every done pops one expectation and compares the whole output record
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            done_count++;
            checks++;
            got_r = {bus.result, bus.result_hi, bus.zout, bus.cout, bus.ovf, bus.z_write, bus.c_write};
            if (q.size() == 0) begin
                $display("FAIL unexpected_done got res=%h hi=%h", bus.result, bus.result_hi);
            end else begin
                exp_r = q.pop_front();
                if (got_r === exp_r) passed++;
                else $display("FAIL done_record got res=%h hi=%h zcv=%b%b%b zw=%b cw=%b expected res=%h hi=%h zcv=%b%b%b zw=%b cw=%b",
                              got_r.res, got_r.hi, got_r.z, got_r.c, got_r.v, got_r.zw, got_r.cw,
                              exp_r.res, exp_r.hi, exp_r.z, exp_r.c, exp_r.v, exp_r.zw, exp_r.cw);
            end
        end
    end

    task automatic mul_seq(input logic [7:0] a, input logic [7:0] b, input exp_t e, input bit intrude);
        @(posedge clk);
        #1;
        bus.op    = 4'hC;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("mul_busy_c%0d", k), {62'd0, bus.busy, bus.done}, 64'd2);
            if (intrude && k == 3) begin
                bus.op    = 4'h4;
                bus.a     = 8'h11;
                bus.b     = 8'h22;
                bus.start = 1'b1;
            end
            if (k == 5) bus.start = 1'b0;
        end
        @(negedge clk);
        check("mul_done_c9", {62'd0, bus.busy, bus.done}, 64'd1);
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        done_count = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 4'h0;
        bus.a      = 8'h00;
        bus.b      = 8'h00;
        bus.cin    = 1'b0;

        add_vec(4'h4, 8'hFF, 8'h01, 1'b0, 8'h00, 1, 1, 0, 1, 1);
        add_vec(4'h6, 8'h80, 8'h01, 1'b0, 8'h7F, 0, 1, 1, 1, 1);
        add_vec(4'h7, 8'h05, 8'h03, 1'b0, 8'h01, 0, 1, 0, 1, 1);
        add_vec(4'hA, 8'h80, 8'h03, 1'b0, 8'hF0, 0, 0, 0, 1, 0);
        add_vec(4'hB, 8'h81, 8'h01, 1'b0, 8'h03, 0, 0, 0, 1, 0);
        add_vec(4'h8, 8'h01, 8'h08, 1'b0, 8'h01, 0, 0, 0, 1, 0);
        add_vec(4'h0, 8'hF0, 8'h3C, 1'b0, 8'h30, 0, 0, 0, 1, 0);
        add_vec(4'h1, 8'h0F, 8'hF0, 1'b0, 8'hFF, 0, 0, 0, 1, 0);
        add_vec(4'h2, 8'hAA, 8'hAA, 1'b0, 8'h00, 1, 0, 0, 1, 0);
        add_vec(4'h2, 8'h5A, 8'h0F, 1'b0, 8'h55, 0, 0, 0, 1, 0);
        add_vec(4'h3, 8'h12, 8'h34, 1'b0, 8'h34, 0, 0, 0, 1, 0);
        add_vec(4'h5, 8'h7F, 8'h00, 1'b1, 8'h80, 0, 0, 1, 1, 1);
        add_vec(4'h9, 8'h80, 8'h07, 1'b0, 8'h01, 0, 0, 0, 1, 0);
        add_vec(4'h8, 8'h81, 8'h01, 1'b0, 8'h02, 0, 0, 0, 1, 0);
        add_vec(4'h4, 8'h70, 8'h70, 1'b0, 8'hE0, 0, 0, 1, 1, 1);
        add_vec(4'h6, 8'h05, 8'h05, 1'b0, 8'h00, 1, 1, 0, 1, 1);
        add_vec(4'h7, 8'h00, 8'h00, 1'b0, 8'hFF, 0, 0, 0, 1, 1);
        add_vec(4'hE, 8'hFF, 8'hFF, 1'b1, 8'h00, 0, 0, 0, 0, 0);
        add_vec(4'hD, 8'h00, 8'h00, 1'b0, 8'h00, 0, 0, 0, 0, 0);
        add_vec(4'hA, 8'h40, 8'h02, 1'b0, 8'h10, 0, 0, 0, 1, 0);
        add_vec(4'hB, 8'h80, 8'h07, 1'b0, 8'h40, 0, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {49'd0, bus.busy, bus.done, bus.result, bus.result_hi, bus.zout, bus.cout,
              bus.ovf, bus.z_write, bus.c_write}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table issued back-to-back: one start per cycle, so done must stay high for the whole run
        base = done_count;
        @(posedge clk);
        #1;
        for (int i = 0; i < vt.size(); i++) begin
            bus.op    = vt[i].op;
            bus.a     = vt[i].a;
            bus.b     = vt[i].b;
            bus.cin   = vt[i].cin;
            bus.start = 1'b1;
            q.push_back(vt[i].e);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        check("table_done_count", 64'(done_count - base), 64'(vt.size()));

        mul_seq(8'hFF, 8'hFF, {8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}, 1'b1);
        mul_seq(8'h0F, 8'h11, {8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}, 1'b0);
        mul_seq(8'h00, 8'h5A, {8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}, 1'b0);
        mul_seq(8'hFF, 8'hFF, {8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}, 1'b0);
        repeat (2) @(posedge clk);
        check("intruder_ignored_queue", 64'(q.size()), 64'd0);

        // Reset in the middle of a multiply: outputs clear at once and no done follows
        @(posedge clk);
        #1;
        bus.op    = 4'hC;
        bus.a     = 8'h37;
        bus.b     = 8'h59;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_reset", {63'd0, bus.busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_clear", {49'd0, bus.busy, bus.done, bus.result, bus.result_hi, bus.zout, bus.cout,
              bus.ovf, bus.z_write, bus.c_write}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        base = done_count;
        repeat (12) @(posedge clk);
        #1;
        check("no_done_after_reset", 64'(done_count - base), 64'd0);
        check("idle_after_reset", {62'd0, bus.busy, bus.done}, 64'd0);

        // Reserved op after reset still completes in one cycle with no flag writes
        bus.op    = 4'hE;
        bus.a     = 8'hA5;
        bus.b     = 8'h5A;
        bus.start = 1'b1;
        q.push_back({8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("reserved_latency", {63'd0, bus.done}, 64'd1);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the ez8 datapath family. It generalises the 8-bit combinational ALU to WIDTH bits, registers its results and flags, and adds rotate, signed overflow and an iterative shift-add multiplier. The block sits between the register file/accumulator read ports and the writeback stage. The sequencer talks to it through a start/busy/done handshake.

Parameters:
WIDTH, 8, datapath width in bits; must be >= 4 and a power of two.
SHW, $clog2(WIDTH), localparam (not overridable); width of the shift amount.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only when busy=0.
op  in  4  operation code; encodings under Behaviour.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for shift ops.
cin  in  1  carry in, used by ADC/SBC.
busy  out  1  multiplier iterating; start is ignored while high.
done  out  1  one-cycle pulse; result and flags are valid and updated.
result  out  WIDTH  result; low word for MUL.
result_hi  out  WIDTH  high word for MUL; 0 for every other op.
zout  out  1  zero flag.
cout  out  1  carry flag.
ovf  out  1  signed overflow (add/sub ops only, else 0).
z_write  out  1  zout is meaningful; valid with done.
c_write  out  1  cout is meaningful; valid with done.

Behaviour:
Reset:
- Asynchronous on reset_n low.
- State=IDLE; busy, done, result, result_hi, zout, cout, ovf, z_write and c_write all 0; multiplier registers 0.
- Reset asserted mid-MUL abandons the operation; no done is produced.

Op encoding:
- 0 AND, 1 OR, 2 XOR, 3 PASSB.
- 4 ADD a+b; 5 ADC a+b+cin.
- 6 SUB a+~b+1; 7 SBC a+~b+cin.
- 8 SLL, 9 SRL, A SRA, B ROL (rotate left). Shift amount is b[SHW-1:0].
- C MUL, unsigned, 2*WIDTH-bit product.
- D-F reserved.

Add/sub:
- Computed at WIDTH+1 bits; cout = bit WIDTH.
- For SUB/SBC, cout=1 means no borrow.
- ovf = (a_msb == b'_msb) && (res_msb != a_msb), where b' is the post-inversion operand.

State machine IDLE / MUL:
- IDLE, start=1, op != C: on that edge, result/flags are computed from a, b, cin and registered; done=1 in the next cycle (latency 1). State stays IDLE.
- IDLE, start=1, op=C: latch a as multiplicand and b as multiplier; clear accumulator; count=0; go to MUL. busy=1 from the next cycle.
- MUL: one multiplier bit per cycle, LSB first. If the bit is set, add the multiplicand to the upper half of the accumulator; then shift the {carry, acc} pair right by 1. count increments each cycle.
- After WIDTH iterations: register the product into result_hi/result; done=1 and busy=0 in the following cycle; return to IDLE. Total latency is WIDTH+1 cycles from the start edge to done.

done and back-to-back starts:
- done is high for exactly one cycle per accepted start.
- A start in the same cycle as done (busy=0) is accepted, so single-cycle ops can issue every cycle.

start while busy:
- Ignored entirely; no queuing.
- Operand inputs may change freely during MUL.

Flags:
- zout = (result==0), or (product==0) for MUL.
- Logic ops 0-3: z_write=1, c_write=0, cout=0.
- Add/sub 4-7: z_write=1, c_write=1.
- Shifts 8-B: z_write=1, c_write=0.
- MUL: z_write=1, c_write=1, cout = (result_hi != 0).
- Reserved ops: complete in 1 cycle with result=0, zout=0, z_write=0, c_write=0 (flags untouched downstream).

Output hold: result, result_hi and flag outputs hold their values until the next done. z_write and c_write are qualified by done only.

Shifts:
- A shift amount of 0 returns a unchanged.
- SRA replicates a[WIDTH-1].
- ROL wraps a[WIDTH-1] into bit 0.

Test Plan:
1. WIDTH=8, ADD a=FF b=01 -> done at cycle 1, result=00, zout=1, cout=1, ovf=0, c_write=1.
2. SUB a=80 b=01 -> result=7F, cout=1, ovf=1. SBC a=05 b=03 cin=0 -> result=01, cout=1.
3. SRA a=80 b=03 -> F0. ROL a=81 b=01 -> 03. SLL a=01 b=08 (amount 0) -> 01. Each has c_write=0.
4. MUL a=FF b=FF -> busy for cycles 1-8, done at cycle 9, result_hi=FE, result=01, cout=1. MUL 0F*11 -> FF/00, cout=0.
5. Start ADD during MUL busy -> ignored, one done only. Back-to-back XOR on consecutive cycles -> done high for 2 consecutive cycles with the correct results.
6. reset_n low at cycle 4 of MUL -> all outputs 0 immediately; no done after release. Op E -> done, result=00, z_write=0, c_write=0.
